// File: rtl/fisc_bus_pkg.sv
// Shared types and constants for the FISC external bus interface unit.
package fisc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } bus_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    // A fetch must be word aligned; a data access must be doubleword aligned.
    localparam logic [63:0] IF_ALIGN_MASK = 64'h3;
    localparam logic [63:0] DM_ALIGN_MASK = 64'h7;

endpackage

// File: rtl/fisc_bus_prio.sv
// Grant selection between fetch and data requesters. Data normally wins;
// a run of DATA_STREAK_MAX data grants while fetch waits forces one fetch.
module fisc_bus_prio
    import fisc_bus_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   grant_en,
    output grant_t gnt
);

    localparam int SW = $clog2(DATA_STREAK_MAX + 2);
    localparam logic [SW-1:0] STREAK_LIM = SW'(DATA_STREAK_MAX);

    logic [SW-1:0] streak;

    // Data wins unless fetch is the only requester or fetch has starved long enough.
    always_comb begin
        gnt = GNT_DM;
        if (if_req && (!dm_req || streak == STREAK_LIM)) begin
            gnt = GNT_IF;
        end
    end

    // Count data grants taken while fetch is waiting; any gap in if_req resets the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
        end else if (!if_req) begin
            streak <= '0;
        end else if (grant_en) begin
            streak <= (gnt == GNT_IF) ? '0 : streak + 1'b1;
        end
    end

endmodule

// File: rtl/fisc_bus_arbiter.sv
// Bus interface unit: arbitrates fetch and data requests onto the single
// external bus and runs each access through setup, strobe and done phases.
//
// state  | meaning
// IDLE   | bus free, requests sampled and granted here
// SETUP  | address (and store data) driven, strobes still high
// STROBE | rd_n or wr_n low, extended while wait_n=0
// DONE   | ack pulse to the granted requester, strobes released
module fisc_bus_arbiter
    import fisc_bus_pkg::*;
#(
    parameter int WAIT_TIMEOUT    = 255,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ack,
    output logic [63:0] dm_rdata,
    output logic        dm_err,
    input  logic        wait_n,
    output logic [63:0] a,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    output logic        d_oe,
    output logic        rd_n,
    output logic        wr_n,
    output logic        opcycle_n,
    output logic        busy
);

    bus_state_t  state, state_nxt;
    grant_t      gnt, gnt_q;
    logic        we_q;
    logic [15:0] wait_cnt;
    logic        any_req;
    logic        grant_en;
    logic        misaligned;
    logic        timeout_hit;
    logic        finish;

    assign any_req = if_req | dm_req;
    assign busy    = (state != IDLE);

    assign misaligned = (gnt == GNT_IF) ? |(if_addr & IF_ALIGN_MASK)
                                        : |(dm_addr & DM_ALIGN_MASK);

    // wait_cnt counts extension cycles already taken; this edge would be one more.
    assign timeout_hit = (WAIT_TIMEOUT != 0) &&
                         (({1'b0, wait_cnt} + 17'd1) == 17'(WAIT_TIMEOUT));
    assign finish = wait_n || timeout_hit;

    fisc_bus_prio #(
        .DATA_STREAK_MAX(DATA_STREAK_MAX)
    ) u_prio (
        .clk     (clk),
        .reset_n (reset_n),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .grant_en(grant_en),
        .gnt     (gnt)
    );

    // Next-state decode; a misaligned request skips the bus and completes at once.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_en  = 1'b1;
                    state_nxt = misaligned ? DONE : SETUP;
                end
            end
            SETUP:   state_nxt = STROBE;
            STROBE:  if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus pins, wait counter and requester results, all registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q     <= GNT_IF;
            we_q      <= 1'b0;
            wait_cnt  <= '0;
            a         <= '0;
            d_out     <= '0;
            d_oe      <= 1'b0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            opcycle_n <= 1'b1;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            dm_ack    <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q <= gnt;
                        we_q  <= (gnt == GNT_DM) && dm_we;
                        if (misaligned) begin
                            if (gnt == GNT_IF) begin
                                if_ack <= 1'b1;
                                if_err <= 1'b1;
                            end else begin
                                dm_ack <= 1'b1;
                                dm_err <= 1'b1;
                            end
                        end else begin
                            a         <= (gnt == GNT_IF) ? if_addr : dm_addr;
                            opcycle_n <= (gnt != GNT_IF);
                            if (gnt == GNT_DM && dm_we) begin
                                d_out <= dm_wdata;
                                d_oe  <= 1'b1;
                            end
                        end
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                    if (we_q) begin
                        wr_n <= 1'b0;
                    end else begin
                        rd_n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (finish) begin
                        rd_n      <= 1'b1;
                        wr_n      <= 1'b1;
                        d_oe      <= 1'b0;
                        opcycle_n <= 1'b1;
                        if (gnt_q == GNT_IF) begin
                            if_ack   <= 1'b1;
                            if_err   <= !wait_n;
                            if_rdata <= wait_n ? d_in[31:0] : 32'd0;
                        end else begin
                            dm_ack   <= 1'b1;
                            dm_err   <= !wait_n;
                            dm_rdata <= wait_n ? d_in : 64'd0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fisc_bus_arbiter.sv
// Self-checking bench for fisc_bus_arbiter: a transaction-timeline model
// predicts every output each cycle, and directed tests pin literal values.
module tb_fisc_bus_arbiter;

    localparam int TO   = 8;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        dm_err;
    logic        wait_n = 1'b1;
    logic [63:0] a;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        d_oe;
    logic        rd_n;
    logic        wr_n;
    logic        opcycle_n;
    logic        busy;

    always #5 clk = ~clk;

    fisc_bus_arbiter #(
        .WAIT_TIMEOUT(TO),
        .DATA_STREAK_MAX(SMAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .wait_n(wait_n), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .rd_n(rd_n), .wr_n(wr_n), .opcycle_n(opcycle_n), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-requester plan for the next transaction: wait cycles and bus read data.
    int          if_w = 0, dm_w = 0;
    logic [63:0] if_din = '0, dm_din = '0;

    // Model: each transaction is a timeline relative to its grant edge g.
    // Cycle n is the interval after rising edge n. Aligned access: setup in
    // cycle g, strobe in cycles g+1..g+S, ack in cycle g+S+1. Misaligned:
    // ack in cycle g. The next grant can happen at edge done+2.
    int          cyc = 0, next_free = 1, streak = 0;
    bit          tr_valid = 0, tr_if = 0, tr_store = 0, tr_mis = 0, tr_err = 0;
    bit          pick_if;
    int          tr_g = 0, tr_s = 0, tr_done = 0, tr_w = 0;
    logic [63:0] tr_addr = '0, tr_wdata = '0, tr_din = '0, e_a = '0;
    logic [31:0] e_if_rdata = '0;
    logic [63:0] e_dm_rdata = '0;
    bit          e_if_err = 0, e_dm_err = 0;
    bit          glog[$];

    // Advance the model at each edge using the requests the DUT also sees.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; next_free = 1; streak = 0; tr_valid = 0;
            e_a = '0; e_if_rdata = '0; e_dm_rdata = '0; e_if_err = 0; e_dm_err = 0;
        end else begin
            cyc = cyc + 1;
            if (tr_valid && !tr_mis && cyc == tr_done) begin
                if (tr_if) begin
                    e_if_rdata = tr_err ? 32'd0 : tr_din[31:0];
                    e_if_err   = tr_err;
                end else begin
                    e_dm_rdata = tr_err ? 64'd0 : tr_din;
                    e_dm_err   = tr_err;
                end
            end
            pick_if = 0;
            if (cyc >= next_free && (if_req || dm_req)) begin
                pick_if  = if_req && (!dm_req || streak == SMAX);
                glog.push_back(pick_if);
                tr_valid = 1;
                tr_g     = cyc;
                tr_if    = pick_if;
                tr_addr  = pick_if ? if_addr : dm_addr;
                tr_store = !pick_if && dm_we;
                tr_wdata = dm_wdata;
                tr_w     = pick_if ? if_w : dm_w;
                tr_din   = pick_if ? if_din : dm_din;
                tr_mis   = pick_if ? (tr_addr % 4 != 0) : (tr_addr % 8 != 0);
                if (tr_mis) begin
                    tr_done = cyc;
                    tr_err  = 1;
                    if (pick_if) e_if_err = 1; else e_dm_err = 1;
                end else begin
                    tr_err  = (TO != 0) && (tr_w >= TO);
                    tr_s    = tr_err ? TO : tr_w + 1;
                    tr_done = cyc + tr_s + 1;
                    e_a     = tr_addr;
                end
                next_free = tr_done + 2;
                if (if_req) streak = pick_if ? 0 : streak + 1;
            end
            if (!if_req) streak = 0;
        end
    end

    // Compare every output against the model; also drive wait_n and d_in from the plan.
    bit in_tr, strobe_on, e_oe, e_opc_low;
    always @(negedge clk) begin
        if (reset_n) begin
            in_tr     = tr_valid && cyc >= tr_g && cyc <= tr_done;
            strobe_on = in_tr && !tr_mis && cyc >= tr_g + 1 && cyc <= tr_g + tr_s;
            e_oe      = in_tr && !tr_mis && tr_store && cyc <= tr_g + tr_s;
            e_opc_low = in_tr && !tr_mis && tr_if && cyc <= tr_g + tr_s;
            chk("busy", busy, in_tr);
            chk("rd_n", rd_n, !(strobe_on && !tr_store));
            chk("wr_n", wr_n, !(strobe_on && tr_store));
            chk("d_oe", d_oe, e_oe);
            chk("opcycle_n", opcycle_n, !e_opc_low);
            chk("a", a, e_a);
            if (e_oe) chk("d_out", d_out, tr_wdata);
            chk("if_ack", if_ack, in_tr && tr_if && cyc == tr_done);
            chk("dm_ack", dm_ack, in_tr && !tr_if && cyc == tr_done);
            chk("if_err", if_err, e_if_err);
            chk("dm_err", dm_err, e_dm_err);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("dm_rdata", dm_rdata, e_dm_rdata);
        end
        wait_n = !(tr_valid && !tr_mis && cyc >= tr_g + 1 && cyc <= tr_g + tr_w && cyc < tr_done);
        d_in   = tr_valid ? tr_din : 64'd0;
    end

    // Wait for the ack of one port, counting latency and strobe/enable cycles.
    task automatic wait_ack(input bit want_if, output int lat, output int rdl,
                            output int wrl, output int oel, output int opl);
        bit got = 0;
        lat = 0; rdl = 0; wrl = 0; oel = 0; opl = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rd_n == 1'b0) rdl++;
            if (wr_n == 1'b0) wrl++;
            if (d_oe == 1'b1) oel++;
            if (opcycle_n == 1'b0) opl++;
            if (want_if ? if_ack : dm_ack) got = 1;
        end
        chk("ack_seen", got, 1'b1);
    endtask

    int lat, rdl, wrl, oel, opl, nack;
    bit order[$];
    bit exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit found;

    initial begin
        #12;
        chk("rst_a", a, 64'd0);
        chk("rst_d_out", d_out, 64'd0);
        chk("rst_d_oe", d_oe, 1'b0);
        chk("rst_rd_n", rd_n, 1'b1);
        chk("rst_wr_n", wr_n, 1'b1);
        chk("rst_opcycle_n", opcycle_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {if_ack, dm_ack, if_err, dm_err}, 4'b0);
        chk("rst_rdata", {32'd0, if_rdata} | dm_rdata, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait fetch.
        if_addr = 64'h100; if_din = 64'h00000000DEADBEEF; if_w = 0; if_req = 1'b1;
        wait_ack(1'b1, lat, rdl, wrl, oel, opl);
        if_req = 1'b0;
        chk("fetch_lat", lat, 3);
        chk("fetch_rd_low", rdl, 1);
        chk("fetch_wr_low", wrl, 0);
        chk("fetch_opcycle_low", opl, 2);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        chk("fetch_err", if_err, 1'b0);
        repeat (2) @(negedge clk);

        // Store extended by three wait cycles.
        dm_addr = 64'h2000; dm_we = 1'b1; dm_wdata = 64'h1122334455667788; dm_w = 3; dm_req = 1'b1;
        wait_ack(1'b0, lat, rdl, wrl, oel, opl);
        dm_req = 1'b0; dm_we = 1'b0;
        chk("store_lat", lat, 6);
        chk("store_wr_low", wrl, 4);
        chk("store_rd_low", rdl, 0);
        chk("store_oe", oel, 5);
        chk("store_err", dm_err, 1'b0);
        repeat (2) @(negedge clk);

        // Misaligned load: immediate error, no bus activity.
        dm_addr = 64'h2003; dm_w = 0; dm_req = 1'b1;
        wait_ack(1'b0, lat, rdl, wrl, oel, opl);
        dm_req = 1'b0;
        chk("misload_lat", lat, 1);
        chk("misload_strobes", rdl + wrl, 0);
        chk("misload_err", dm_err, 1'b1);
        chk("misload_a", a, 64'h2000);
        @(negedge clk);

        // Fetch alignment boundary: 0x102 is bad, 0x104 is fine.
        if_addr = 64'h102; if_req = 1'b1;
        wait_ack(1'b1, lat, rdl, wrl, oel, opl);
        if_req = 1'b0;
        chk("misfetch_lat", lat, 1);
        chk("misfetch_err", if_err, 1'b1);
        @(negedge clk);
        if_addr = 64'h104; if_din = 64'h0000000012345678; if_w = 1; if_req = 1'b1;
        wait_ack(1'b1, lat, rdl, wrl, oel, opl);
        if_req = 1'b0;
        chk("fetch4_lat", lat, 4);
        chk("fetch4_err", if_err, 1'b0);
        chk("fetch4_rdata", if_rdata, 32'h12345678);
        repeat (2) @(negedge clk);

        // Both requesters held continuously: streak forces fetch every fifth grant.
        if_addr = 64'h1000; if_din = 64'h00000000A0000000; if_w = 0;
        dm_addr = 64'h3000; dm_din = 64'hB000000000000000; dm_w = 0;
        glog.delete();
        if_req = 1'b1; dm_req = 1'b1;
        nack = 0;
        for (int i = 0; i < 400 && nack < 10; i++) begin
            @(negedge clk);
            if (if_ack) begin
                order.push_back(1'b1); nack++;
                if_addr = if_addr + 64'd4; if_din = if_din + 64'd1;
            end
            if (dm_ack) begin
                order.push_back(1'b0); nack++;
                dm_addr = dm_addr + 64'd8; dm_din = dm_din + 64'd3;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("streak_acks", nack, 10);
        for (int i = 0; i < 10; i++) begin
            chk("grant_order_dut", (i < order.size()) ? order[i] : 1'bx, exp_order[i]);
            chk("grant_order_model", (i < glog.size()) ? glog[i] : 1'bx, exp_order[i]);
        end
        repeat (3) @(negedge clk);

        // Load held off by wait_n until the timeout aborts it.
        dm_addr = 64'h4000; dm_din = 64'hFFFFFFFFFFFFFFFF; dm_w = 100; dm_req = 1'b1;
        wait_ack(1'b0, lat, rdl, wrl, oel, opl);
        dm_req = 1'b0;
        chk("to_lat", lat, 10);
        chk("to_rd_low", rdl, 8);
        chk("to_err", dm_err, 1'b1);
        chk("to_rdata", dm_rdata, 64'd0);
        repeat (2) @(negedge clk);

        // Reset pulsed in the middle of a strobe.
        dm_addr = 64'h5000; dm_din = 64'h55; dm_w = 100; dm_req = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rd_n == 1'b0) found = 1;
        end
        chk("rst_test_strobe_seen", found, 1'b1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_rd_n", rd_n, 1'b1);
        chk("midrst_wr_n", wr_n, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ack", dm_ack, 1'b0);
        chk("midrst_a", a, 64'd0);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dm_ack || if_ack) nack++;
        end
        chk("postrst_no_ack", nack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
